aes_round_seq: RTL

Iterative AES encryption round sequencer. It accepts one 128-bit plaintext block, applies the initial AddRoundKey, and then runs one full round per clock (SubBytes, ShiftRows, MixColumns, AddRoundKey) on a single registered state. The final round skips MixColumns. Round keys come from an external key-expansion store, indexed by this block. It sits between the host block interface and the existing combinational mix_cols / round-function datapath.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_round_fn.sv | 29 ++
 rtl/mix_cols.sv | 22 ++
 rtl/aes_round_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, legal round counts, GF(2^8) helpers, S-box, FSM states.
// Bytes are column-major with byte 0 in bits [127:120].
package aes_pkg;

  localparam int unsigned NB       = 4;
  localparam int unsigned WordW    = 32;
  localparam int unsigned StateW   = NB * WordW;
  localparam int unsigned NrAes128 = 10;
  localparam int unsigned NrAes192 = 12;
  localparam int unsigned NrAes256 = 14;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } aes_fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = a;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_fn.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_fn
  import aes_pkg::*;
(
  input  logic [StateW-1:0] state_i,
  input  logic [StateW-1:0] rk_i,
  input  logic              last_i,
  output logic [StateW-1:0] state_o
);

  logic [StateW-1:0] sr;
  logic [StateW-1:0] mc;

  // Output byte (row r, column c) is the substituted input byte from column (c + r) mod NB.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < NB; r++) begin : g_row
      assign sr[StateW - 1 - 8 * (NB * c + r) -: 8] =
          sbox(state_i[StateW - 1 - 8 * (NB * ((c + r) % NB) + r) -: 8]);
    end
  end

  mix_cols u_mix_cols (
    .state_i(sr),
    .state_o(mc)
  );

  assign state_o = (last_i ? sr : mc) ^ rk_i;

endmodule

// File: rtl/mix_cols.sv
// Combinational AES MixColumns over a full 128-bit column-major state.
module mix_cols
  import aes_pkg::*;
(
  input  logic [StateW-1:0] state_i,
  output logic [StateW-1:0] state_o
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_i[StateW - 1 - WordW * c -: 8];
    assign a1 = state_i[StateW - 9 - WordW * c -: 8];
    assign a2 = state_i[StateW - 17 - WordW * c -: 8];
    assign a3 = state_i[StateW - 25 - WordW * c -: 8];

    assign state_o[StateW - 1 - WordW * c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign state_o[StateW - 9 - WordW * c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign state_o[StateW - 17 - WordW * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign state_o[StateW - 25 - WordW * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES encryption sequencer: one round per clock on a single registered state.
// Optional AES_ROUND_TRACE_EN adds per-update trace outputs.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR     = 10,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [StateW-1:0] pt_i,
  output logic [RIDX_W-1:0] rk_idx_o,
  input  logic [StateW-1:0] rk_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [StateW-1:0] ct_o,
  output logic              busy_o
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic              trace_valid_o,
  output logic [StateW-1:0] trace_state_o,
  output logic [RIDX_W-1:0] trace_rnd_o
`endif
);

  if (!(NR == NrAes128 || NR == NrAes192 || NR == NrAes256)) begin : g_bad_nr
    $error("aes_round_seq: NR must be 10, 12 or 14");
  end
  if ((NR >> RIDX_W) != 0) begin : g_bad_ridx
    $error("aes_round_seq: RIDX_W too narrow for NR");
  end

  localparam logic [RIDX_W-1:0] RndLast = RIDX_W'(NR);

  aes_fsm_e          st_q, st_d;
  logic [StateW-1:0] state_q, state_d;
  logic [RIDX_W-1:0] rnd_q, rnd_d;
  logic [StateW-1:0] round_out;
  logic              last;

  assign last = (rnd_q == RndLast);

  aes_round_fn u_round_fn (
    .state_i(state_q),
    .rk_i   (rk_i),
    .last_i (last),
    .state_o(round_out)
  );

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = pt_i ^ rk_i;
          rnd_d   = RIDX_W'(1);
          st_d    = StRound;
        end
      end
      StRound: begin
        state_d = round_out;
        // Counter holds at NR through DONE; rk_idx keeps pointing at the last key.
        if (last) st_d = StDone;
        else      rnd_d = rnd_q + 1'b1;
      end
      StDone: begin
        if (out_ready_i) begin
          st_d  = StIdle;
          rnd_d = '0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready_o  = (st_q == StIdle) && rst_n;
  assign rk_idx_o    = rnd_q;
  assign out_valid_o = (st_q == StDone);
  assign ct_o        = (st_q == StDone) ? state_q : '0;
  assign busy_o      = (st_q != StIdle);

`ifdef AES_ROUND_TRACE_EN
  logic              load;
  logic              trace_valid_q;
  logic [RIDX_W-1:0] trace_rnd_q;

  assign load = ((st_q == StIdle) && in_valid_i) || (st_q == StRound);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid_q <= 1'b0;
      trace_rnd_q   <= '0;
    end else begin
      trace_valid_q <= load;
      if (load) trace_rnd_q <= rnd_q;
    end
  end

  assign trace_valid_o = trace_valid_q;
  assign trace_state_o = state_q;
  assign trace_rnd_o   = trace_rnd_q;
`endif

endmodule
